// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, enable levels and stall-bit positions for the EX/MEM pipeline register.
// The per-edge action decode lives here so the priority order is written in one place.
package ex_mem_reg_pkg;

  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;
  localparam int StallBus     = 6;
  localparam int CntBus       = 2;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADVANCE
  } action_e;

  // EX stopped with MEM running becomes a bubble; EX-go with MEM-stop is treated as advance.
  function automatic action_e next_action(input logic rst, input logic flush,
                                          input logic ex_stop, input logic mem_stop);
    if (rst == RstEnable) return ACT_RESET;
    if (flush) return ACT_FLUSH;
    if (ex_stop == Stop && mem_stop == NoStop) return ACT_BUBBLE;
    if (ex_stop == Stop) return ACT_HOLD;
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-to-MEM bus: stall/flush control, EX results in, registered MEM results and MADD feedback out.
interface ex_mem_reg_if
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int CNT_W  = CntBus
);

  logic [StallBus-1:0] stall;
  logic                flush;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] hilo_i;
  logic [CNT_W-1:0]    cnt_i;

  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [2*DATA_W-1:0] hilo_o;
  logic [CNT_W-1:0]    cnt_o;

  modport master (
    output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

  modport slave (
    input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: one bank of flops behind a reset/flush/bubble/hold/advance mux.
// hilo_o/cnt_o carry a MADD/MSUB partial product across the EX self-stall.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int CNT_W  = CntBus
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_reg_if.slave  bus
);

  logic [ADDR_W-1:0]   r_mem_wd;
  logic                r_mem_wreg;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_whilo;
  logic [DATA_W-1:0]   r_mem_hi;
  logic [DATA_W-1:0]   r_mem_lo;
  logic [2*DATA_W-1:0] r_hilo;
  logic [CNT_W-1:0]    r_cnt;

  action_e w_act;

  always_comb begin
    w_act = next_action(rst, bus.flush, bus.stall[STALL_EX], bus.stall[STALL_MEM]);
  end

  always_ff @(posedge clk) begin
    case (w_act)
      ACT_RESET, ACT_FLUSH: begin
        r_mem_wd    <= '0;
        r_mem_wreg  <= WriteDisable;
        r_mem_wdata <= ZeroWord;
        r_mem_whilo <= WriteDisable;
        r_mem_hi    <= ZeroWord;
        r_mem_lo    <= ZeroWord;
        r_hilo      <= '0;
        r_cnt       <= '0;
      end
      // NOP into MEM, but keep the accumulator EX will read back next cycle.
      ACT_BUBBLE: begin
        r_mem_wd    <= '0;
        r_mem_wreg  <= WriteDisable;
        r_mem_wdata <= ZeroWord;
        r_mem_whilo <= WriteDisable;
        r_mem_hi    <= ZeroWord;
        r_mem_lo    <= ZeroWord;
        r_hilo      <= bus.hilo_i;
        r_cnt       <= bus.cnt_i;
      end
      ACT_HOLD: begin
      end
      default: begin
        r_mem_wd    <= bus.ex_wd;
        r_mem_wreg  <= bus.ex_wreg;
        r_mem_wdata <= bus.ex_wdata;
        r_mem_whilo <= bus.ex_whilo;
        r_mem_hi    <= bus.ex_hi;
        r_mem_lo    <= bus.ex_lo;
        r_hilo      <= '0;
        r_cnt       <= '0;
      end
    endcase
  end

  assign bus.mem_wd    = r_mem_wd;
  assign bus.mem_wreg  = r_mem_wreg;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_whilo = r_mem_whilo;
  assign bus.mem_hi    = r_mem_hi;
  assign bus.mem_lo    = r_mem_lo;
  assign bus.hilo_o    = r_hilo;
  assign bus.cnt_o     = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed scenarios with literal expectations, then random
// traffic against a behavioural model; a monitor pops one expectation per clock edge.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  out_t m;
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference: what MEM must show after an edge given the current inputs and previous outputs.
  function automatic out_t model_next(out_t cur);
    out_t n;
    n = cur;
    if (rst || bus.flush) begin
      n = '0;
    end else if (bus.stall[3] && !bus.stall[4]) begin
      n = '0;
      n.hilo = bus.hilo_i;
      n.cnt  = bus.cnt_i;
    end else if (bus.stall[3]) begin
      n = cur;
    end else begin
      n.wd    = bus.ex_wd;
      n.wreg  = bus.ex_wreg;
      n.wdata = bus.ex_wdata;
      n.whilo = bus.ex_whilo;
      n.hi    = bus.ex_hi;
      n.lo    = bus.ex_lo;
      n.hilo  = '0;
      n.cnt   = '0;
    end
    return n;
  endfunction

  function automatic out_t mk(logic [4:0] wd, logic wreg, logic [31:0] wdata, logic whilo,
                              logic [31:0] hi, logic [31:0] lo, logic [63:0] hilo, logic [1:0] cnt);
    out_t o;
    o.wd = wd; o.wreg = wreg; o.wdata = wdata; o.whilo = whilo;
    o.hi = hi; o.lo = lo; o.hilo = hilo; o.cnt = cnt;
    return o;
  endfunction

  task automatic step_exp(input string tag, input out_t exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
    m = exp;
    @(posedge clk);
    #2;
  endtask

  task automatic step(input string tag);
    step_exp(tag, model_next(m));
  endtask

  // Monitor: every edge presents a new register value; compare against the oldest expectation.
  initial begin
    exp_t e;
    out_t act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        act = mk(bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
                 bus.mem_hi, bus.mem_lo, bus.hilo_o, bus.cnt_o);
        n_total++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      assert (!(bus.stall[3] == 1'b0 && bus.stall[4] == 1'b1))
        else $error("illegal stall combination EX-go/MEM-stop: %b", bus.stall);
    end
  end

  initial begin
    logic [5:0] s;
    m = '0;
    rst = 1'b1;
    bus.stall = '0;   bus.flush = 1'b0;
    bus.ex_wd = '0;   bus.ex_wreg = 1'b1;  bus.ex_wdata = 32'hDEADBEEF;
    bus.ex_whilo = 1'b0; bus.ex_hi = '0;   bus.ex_lo = '0;
    bus.hilo_i = '0;  bus.cnt_i = '0;

    step_exp("reset_0", '0);
    step_exp("reset_1", '0);
    rst = 1'b0;
    step_exp("reset_release", mk(5'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));

    bus.ex_wd = 5'd7; bus.ex_wdata = 32'h0000FFFF; bus.ex_whilo = 1'b1;
    bus.ex_hi = 32'h1; bus.ex_lo = 32'h2;
    step_exp("advance", mk(5'd7, 1'b1, 32'h0000FFFF, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));

    bus.stall = 6'b001111; bus.hilo_i = 64'h0000_0001_0000_0002; bus.cnt_i = 2'd1;
    step_exp("bubble", mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0000_0001_0000_0002, 2'd1));
    bus.stall = '0; bus.hilo_i = 64'h0000_0003_0000_0004; bus.cnt_i = 2'd0;
    step_exp("bubble_exit", mk(5'd7, 1'b1, 32'h0000FFFF, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));

    bus.ex_wdata = 32'hA5A5A5A5;
    step_exp("hold_load", mk(5'd7, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));
    bus.stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      bus.ex_wdata = ~bus.ex_wdata;
      step_exp("hold", mk(5'd7, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));
    end

    bus.stall = 6'b001111; bus.hilo_i = 64'h1234_5678_9ABC_DEF0; bus.cnt_i = 2'd1;
    step_exp("madd_bubble", mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h1234_5678_9ABC_DEF0, 2'd1));
    bus.stall = 6'b011111; bus.hilo_i = 64'h0;
    step_exp("madd_hold", mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h1234_5678_9ABC_DEF0, 2'd1));
    bus.flush = 1'b1;
    step_exp("flush", '0);
    bus.flush = 1'b0; bus.stall = '0;
    step_exp("post_flush", mk(5'd7, 1'b1, 32'h5A5A5A5A, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));
    bus.flush = 1'b1; rst = 1'b1;
    step_exp("flush_rst", '0);
    bus.flush = 1'b0; rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      s = 6'($urandom);
      if (!s[3]) s[4] = 1'b0;
      bus.stall    = s;
      bus.flush    = ($urandom_range(15) == 0);
      rst          = ($urandom_range(63) == 0);
      bus.ex_wd    = 5'($urandom);
      bus.ex_wreg  = 1'($urandom);
      bus.ex_wdata = $urandom;
      bus.ex_whilo = 1'($urandom);
      bus.ex_hi    = $urandom;
      bus.ex_lo    = $urandom;
      bus.hilo_i   = {$urandom, $urandom};
      bus.cnt_i    = 2'($urandom);
      step("random");
    end

    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
